// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        POR_HOLD,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_e;

    localparam int LOSS_CNT_W = 8;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the refclk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-qualification / staggered domain-release sequencer.
// Optional lock_loss_cnt output is built when PLL_RESET_SEQUENCER_LOSS_CNT_EN is defined.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int POR_CYCLES         = 1024,
    parameter int LOCK_STABLE_CYCLES = 4096,
    parameter int LOCK_TIMEOUT       = 1048576,
    parameter int MAX_RETRIES        = 3,
    parameter int NUM_DOMAINS        = 3,
    parameter int STAGGER            = 16
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic [NUM_DOMAINS-1:0]             dom_reset,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]              lock_loss_cnt
`endif
);

    localparam int RETRY_W     = $clog2(MAX_RETRIES + 1);
    localparam int RELEASE_END = (NUM_DOMAINS - 1) * STAGGER;
    localparam int TIMER_MAX   = max_of4(POR_CYCLES - 1, LOCK_TIMEOUT - 1,
                                         LOCK_STABLE_CYCLES - 1, RELEASE_END);
    localparam int TIMER_W     = count_width(TIMER_MAX);

    localparam logic [TIMER_W-1:0] POR_LAST     = TIMER_W'(POR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RELEASE_LAST = TIMER_W'(RELEASE_END);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic lock_s;

    pll_lock_sync u_lock_sync (
        .clk      (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    state_e                   state_q, state_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [RETRY_W-1:0]       retry_q, retry_d;
    logic                     pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0]   dom_reset_q, dom_reset_d;
    logic                     ready_q, ready_d;
    logic                     fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        retry_d = retry_q;

        if (restart) begin
            state_d = POR_HOLD;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                POR_HOLD: begin
                    if (timer_q == POR_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end
                end
                WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle still wins.
                    if (lock_s) begin
                        state_d = STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = FAULT;
                        end else begin
                            state_d = POR_HOLD;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = RELEASE;
                        timer_d = '0;
                    end
                end
                RELEASE, RUN: begin
                    // Lock loss starts a fresh episode, so the retry budget is restored.
                    if (!lock_s) begin
                        state_d = POR_HOLD;
                        timer_d = '0;
                        retry_d = '0;
                    end else if (state_q == RUN) begin
                        timer_d = timer_q;
                    end else if (timer_q == RELEASE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                    end
                end
                FAULT: begin
                    timer_d = timer_q;
                end
                default: begin
                    state_d = POR_HOLD;
                    timer_d = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_d = (state_d == POR_HOLD) || (state_d == FAULT);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (state_d == RUN) begin
                dom_reset_d[i] = 1'b0;
            end else if (state_d == RELEASE) begin
                dom_reset_d[i] = (timer_d < TIMER_W'(i * STAGGER));
            end else begin
                dom_reset_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= POR_HOLD;
            timer_q     <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            dom_reset_q <= '1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            dom_reset_q <= dom_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign dom_reset   = dom_reset_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Survives restart; only rst clears the lifetime loss count.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (!restart && !lock_s && (state_q == RELEASE || state_q == RUN) &&
            (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed timing checks plus randomized lock activity.
module tb_pll_reset_sequencer;

    localparam int P_POR = 8;
    localparam int P_LS  = 16;
    localparam int P_TO  = 64;
    localparam int P_MR  = 2;
    localparam int P_ND  = 3;
    localparam int P_STG = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic [2:0] dom_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    pll_reset_sequencer #(
        .POR_CYCLES         (P_POR),
        .LOCK_STABLE_CYCLES (P_LS),
        .LOCK_TIMEOUT       (P_TO),
        .MAX_RETRIES        (P_MR),
        .NUM_DOMAINS        (P_ND),
        .STAGGER            (P_STG)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_rst       (pll_rst),
        .dom_reset     (dom_reset),
        .ready         (ready),
        .fault         (fault),
        .retry_count   (retry_count)
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: phase plus the edge number at which it was entered;
    // lock is seen two edges after it is driven.
    typedef enum int {M_HOLD, M_WAIT, M_STABLE, M_RELEASE, M_RUN, M_FAULT} mphase_e;
    mphase_e ph = M_HOLD;
    int      edge_n = 0;
    int      t0 = 0;
    int      retries = 0;
    int      losses = 0;
    bit      lq[$];

    function automatic void go(input mphase_e p);
        ph = p;
        t0 = edge_n;
    endfunction

    function automatic void model_step(input bit r, input bit rs, input bit pl);
        bit ls;
        int el;
        edge_n++;
        if (r) begin
            go(M_HOLD);
            retries = 0;
            losses  = 0;
            lq = '{1'b0, 1'b0};
        end else begin
            ls = lq.pop_front();
            lq.push_back(pl);
            el = edge_n - t0;
            if (rs) begin
                go(M_HOLD);
                retries = 0;
            end else begin
                case (ph)
                    M_HOLD:   if (el == P_POR) go(M_WAIT);
                    M_WAIT: begin
                        if (ls) go(M_STABLE);
                        else if (el == P_TO) begin
                            if (retries == P_MR) go(M_FAULT);
                            else begin
                                retries++;
                                go(M_HOLD);
                            end
                        end
                    end
                    M_STABLE: begin
                        if (!ls) go(M_WAIT);
                        else if (el == P_LS) go(M_RELEASE);
                    end
                    M_RELEASE, M_RUN: begin
                        if (!ls) begin
                            go(M_HOLD);
                            retries = 0;
                            if (losses < 255) losses++;
                        end else if (ph == M_RELEASE && el == (P_ND - 1) * P_STG + 1) begin
                            go(M_RUN);
                        end
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic compare_outputs();
        logic [2:0] exp_dom;
        int e;
        e = edge_n - t0;
        exp_dom = 3'b111;
        if (ph == M_RUN) exp_dom = 3'b000;
        else if (ph == M_RELEASE)
            for (int i = 0; i < P_ND; i++) exp_dom[i] = !(e >= i * P_STG);
        check_eq("pll_rst", 32'(pll_rst), 32'(ph == M_HOLD || ph == M_FAULT));
        check_eq("dom_reset", 32'(dom_reset), 32'(exp_dom));
        check_eq("ready", 32'(ready), 32'(ph == M_RUN));
        check_eq("fault", 32'(fault), 32'(ph == M_FAULT));
        check_eq("retry_count", 32'(retry_count), 32'(retries));
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        check_eq("lock_loss_cnt", 32'(lock_loss_cnt), 32'(losses));
`endif
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step(rst, restart, pll_locked);
        if (rst) cyc = 0;
        else cyc++;
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        restart = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int t_pll, t_d0, t_d1, t_d2, t_rdy;

    // Runs from cycle 0 with lock arriving at cycle 20, optionally dropped for one cycle.
    task automatic start_sequence(input int glitch_cyc);
        t_pll = -1; t_d0 = -1; t_d1 = -1; t_d2 = -1; t_rdy = -1;
        while (cyc < 200 && !ready) begin
            if (cyc == 20) pll_locked = 1'b1;
            if (cyc == glitch_cyc) pll_locked = 1'b0;
            if (cyc == glitch_cyc + 1) pll_locked = 1'b1;
            tick();
            if (t_pll < 0 && !pll_rst) t_pll = cyc;
            if (t_d0 < 0 && !dom_reset[0]) t_d0 = cyc;
            if (t_d1 < 0 && !dom_reset[1]) t_d1 = cyc;
            if (t_d2 < 0 && !dom_reset[2]) t_d2 = cyc;
            if (t_rdy < 0 && ready) t_rdy = cyc;
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int k;
        k = 0;
        while (!ready && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(ready), 32'd1);
    endtask

    task automatic wait_pll_rst(input string tag, input int budget, output int lat);
        lat = 0;
        while (!pll_rst && lat < budget) begin
            tick();
            lat++;
        end
        check_eq(tag, 32'(pll_rst), 32'd1);
    endtask

    initial begin
        int lat;
        int hi_cnt;
        int t_fault;
        int dur;

        // Reset state and clean start
        pll_locked = 1'b0;
        do_reset();
        check_eq("rst_pll_rst", 32'(pll_rst), 32'd1);
        check_eq("rst_dom_reset", 32'(dom_reset), 32'h7);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_retry", 32'(retry_count), 32'd0);
        start_sequence(-10);
        check_eq("clean_pll_rst_fall", t_pll, 8);
        check_eq("clean_dom0_fall", t_d0, 39);
        check_eq("clean_dom1_fall", t_d1, 43);
        check_eq("clean_dom2_fall", t_d2, 47);
        check_eq("clean_ready", t_rdy, 48);

        // Loss of lock while running
        repeat ($urandom_range(5, 30)) tick();
        pll_locked = 1'b0;
        wait_pll_rst("loss_pll_rst", 10, lat);
        check_eq("loss_latency", lat, 3);
        check_eq("loss_dom_reset", 32'(dom_reset), 32'h7);
        check_eq("loss_ready", 32'(ready), 32'd0);
        check_eq("loss_retry", 32'(retry_count), 32'd0);
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        check_eq("loss_cnt_one", 32'(lock_loss_cnt), 32'd1);
`endif

        // No lock at all: retries then fault
        do_reset();
        hi_cnt = pll_rst ? 1 : 0;
        t_fault = -1;
        while (cyc < 230) begin
            tick();
            if (cyc < 216 && pll_rst) hi_cnt++;
            if (t_fault < 0 && fault) t_fault = cyc;
            if (cyc == 100) check_eq("nolock_retry1", 32'(retry_count), 32'd1);
            if (cyc == 200) check_eq("nolock_retry2", 32'(retry_count), 32'd2);
        end
        check_eq("nolock_pll_rst_hi_cycles", hi_cnt, 24);
        check_eq("nolock_fault_cycle", t_fault, 216);
        check_eq("fault_pll_rst", 32'(pll_rst), 32'd1);
        check_eq("fault_dom_reset", 32'(dom_reset), 32'h7);

        // Restart out of FAULT
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("restart_fault", 32'(fault), 32'd0);
        check_eq("restart_retry", 32'(retry_count), 32'd0);
        check_eq("restart_pll_rst", 32'(pll_rst), 32'd1);
        pll_locked = 1'b1;
        wait_ready("restart_ready", 200);

        // One-cycle lock glitch during qualification
        pll_locked = 1'b0;
        do_reset();
        start_sequence(31);
        check_eq("glitch_dom0_fall", t_d0, 51);
        check_eq("glitch_ready", t_rdy, 60);

        // rst in the middle of RELEASE
        pll_locked = 1'b0;
        do_reset();
        while (cyc < 40) begin
            if (cyc == 20) pll_locked = 1'b1;
            tick();
        end
        check_eq("midrel_dom_reset", 32'(dom_reset), 32'h6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrel_rst_dom_reset", 32'(dom_reset), 32'h7);
        check_eq("midrel_rst_pll_rst", 32'(pll_rst), 32'd1);
        check_eq("midrel_rst_ready", 32'(ready), 32'd0);

        // Randomized lock activity with sporadic restart and rst
        for (int ep = 0; ep < 60; ep++) begin
            pll_locked = ($urandom_range(0, 9) < 7);
            dur = pll_locked ? $urandom_range(1, 150) : $urandom_range(1, 40);
            for (int k = 0; k < dur; k++) begin
                restart = ($urandom_range(0, 199) == 0);
                rst = ($urandom_range(0, 599) == 0);
                tick();
            end
            restart = 1'b0;
            rst = 1'b0;
        end

        // Repeated lock loss drives the loss counter into saturation
        pll_locked = 1'b0;
        do_reset();
        for (int it = 0; it < 260; it++) begin
            pll_locked = 1'b1;
            wait_ready("sat_ready", 200);
            if (!ready) break;
            pll_locked = 1'b0;
            wait_pll_rst("sat_pll_rst", 10, lat);
            if (it == 100) begin
                restart = 1'b1;
                tick();
                restart = 1'b0;
            end
        end
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        check_eq("loss_cnt_saturated", 32'(lock_loss_cnt), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
